// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// operation encoding and default geometry.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CLA_WIDTH  = 32;
  localparam int CLA_BLK    = 4;
  localparam int CLA_STAGES = 4;

  // Maps the op code onto "invert operand B"; unknown codes fall back to add.
  function automatic logic op_invert(input logic op);
    unique case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cla_blk.sv
// One BLK-bit carry-lookahead block: every internal carry is a flat
// sum of products of bit generate/propagate terms and the block carry-in.
module cla_blk
  import cla_pkg::*;
#(
  parameter int BLK = CLA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           p,
  output logic           g
);

  logic [BLK-1:0] pb;
  logic [BLK-1:0] gb;
  logic [BLK-1:0] c;
  logic           term;

  assign pb = a ^ b;
  assign gb = a & b;

  always_comb begin
    c    = '0;
    g    = 1'b0;
    p    = 1'b1;
    term = 1'b0;
    // c[i] = cin & p[i-1:0]  |  OR_j ( g[j] & p[i-1:j+1] )
    for (int i = 0; i < BLK; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & pb[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gb[j];
        for (int m = j + 1; m < i; m++) term = term & pb[m];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < BLK; j++) begin
      term = gb[j];
      for (int m = j + 1; m < BLK; m++) term = term & pb[m];
      g = g | term;
      p = p & pb[j];
    end
  end

  assign sum  = pb ^ c;
  assign cout = g | (p & cin);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: each stage resolves G lookahead blocks and hands
// its carry, finished low sum bits and remaining high operand bits onward.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int BLK    = CLA_BLK,
  parameter int STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLK;
  localparam int G    = NBLK / STAGES;
  localparam int SW   = G * BLK;

  if ((WIDTH % BLK) != 0 || WIDTH < 8 || STAGES < 1 || STAGES > NBLK || (NBLK % STAGES) != 0)
  begin : g_bad_params
    $error("cla_pipe_addsub: illegal WIDTH/BLK/STAGES combination");
  end

  // Stage k inputs; index 0 is the port side, index k>0 is stage k-1's register.
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_s   [STAGES];
  logic              st_c   [STAGES];
  logic              st_sub [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] adv;

  assign st_a[0]   = a;
  assign st_b[0]   = b;
  assign st_s[0]   = '0;
  assign st_c[0]   = cin;
  assign st_sub[0] = op_invert(sub);

  // Handshake: a beat moves across a rising edge when valid && ready are both
  // high; ready is derived from downstream occupancy only, never from valid.
  assign in_ready  = adv[0];
  assign out_valid = vld_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) vld_q[k] <= v_in[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [SW-1:0]    bsum;
    logic             co [G];
    logic             bp [G];
    logic             bg [G];
    logic             cc [G+1];
    logic             grp_g;
    logic             grp_p;
    logic             c_out;
    logic [WIDTH-1:0] s_next;

    // A stage moves when it, or any stage after it, has a free slot.
    assign adv[k] = out_ready | ~(&vld_q[STAGES-1:k]);

    if (k == 0) begin : g_vin_first
      assign v_in[k] = in_valid;
    end else begin : g_vin_next
      assign v_in[k] = vld_q[k-1];
    end

    assign cc[0] = st_c[k];

    for (genvar gi = 0; gi < G; gi++) begin : g_blk
      logic [BLK-1:0] bx;
      assign bx = st_b[k][LO + gi*BLK +: BLK] ^ {BLK{st_sub[k]}};

      cla_blk #(.BLK(BLK)) u_blk (
        .a    (st_a[k][LO + gi*BLK +: BLK]),
        .b    (bx),
        .cin  (cc[gi]),
        .sum  (bsum[gi*BLK +: BLK]),
        .cout (co[gi]),
        .p    (bp[gi]),
        .g    (bg[gi])
      );

      assign cc[gi+1] = co[gi];
    end

    // Stage carry-out from the group P/G so it does not wait on the block ripple.
    always_comb begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < G; i++) begin
        grp_g = bg[i] | (bp[i] & grp_g);
        grp_p = grp_p & bp[i];
      end
      c_out = grp_g | (grp_p & st_c[k]);
    end

    always_comb begin
      s_next            = st_s[k];
      s_next[LO +: SW]  = bsum;
    end

    if (k < STAGES - 1) begin : g_mid
      localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << ((k + 1) * SW);

      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             sub_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
          sub_q <= 1'b0;
        end else if (adv[k] && v_in[k]) begin
          a_q   <= st_a[k] & HI_MASK;
          b_q   <= st_b[k] & HI_MASK;
          s_q   <= s_next;
          c_q   <= c_out;
          sub_q <= st_sub[k];
        end
      end

      assign st_a[k+1]   = a_q;
      assign st_b[k+1]   = b_q;
      assign st_s[k+1]   = s_q;
      assign st_c[k+1]   = c_q;
      assign st_sub[k+1] = sub_q;
    end else begin : g_last
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;
      logic             zero_q;
      logic             msb_cin;

      // Carry into the MSB recovered from the MSB's own sum bit.
      assign msb_cin = st_a[k][WIDTH-1] ^ st_b[k][WIDTH-1] ^ st_sub[k] ^ s_next[WIDTH-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k] && v_in[k]) begin
          sum_q  <= s_next;
          cout_q <= c_out;
          ovf_q  <= msb_cin ^ c_out;
          zero_q <= (s_next == '0);
        end
      end

      assign sum  = sum_q;
      assign cout = cout_q;
      assign ovf  = ovf_q;
      assign zero = zero_q;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: drivers push expected results,
// a monitor pops and compares whenever a result beat is handed off.
module tb_cla_pipe_addsub;

  localparam int W  = 32;
  localparam int RW = W + 3;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [RW-1:0] exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;

  logic [RW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            rdy_mode = 0;
  vec_t          vecs[10];

  cla_pipe_addsub #(.WIDTH(32), .BLK(4), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [RW-1:0] model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    bx   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mc};
    s    = full[W-1:0];
    ov   = (ma[W-1] == bx[W-1]) && (s[W-1] != ma[W-1]);
    return {full[W], ov, (s == '0), s};
  endfunction

  function automatic vec_t mk(logic [W-1:0] va, logic [W-1:0] vb, logic vc, logic vs,
                              logic co, logic ov, logic z, logic [W-1:0] s);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.exp = {co, ov, z, s};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input vec_t v);
    int n = 0;
    bit acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      #1;
      acc = in_ready;
      n++;
    end
    if (acc) exp_q.push_back(v.exp);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending results exp=0", exp_q.size());
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [RW-1:0] cur;
    logic [RW-1:0] held;
    logic [RW-1:0] e;
    bit            prev_stall;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {cout, ovf, zero, sum};
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'(cur), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result got=%0h exp=none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(cur), 64'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = cur;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   accepted;
    bit   seen;
    vec_t v;

    vecs[0] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000);
    vecs[1] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000);
    vecs[2] = mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE);
    vecs[3] = mk(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF);
    vecs[4] = mk(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00010000);
    vecs[5] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    vecs[6] = mk(32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000);
    vecs[7] = mk(32'h0000000F, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000010);
    vecs[8] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000);
    vecs[9] = mk(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_flags", 64'({cout, ovf, zero}), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Latency on an empty pipe, then the directed table back to back.
    send(vecs[0]);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      idle();
      n++;
      #3;
      seen = out_valid;
    end
    chk("latency_cycles", 64'(n), 64'd4);
    wait_drain(50);

    for (int i = 0; i < 10; i++) send(vecs[i]);
    idle();
    wait_drain(50);

    // Full pipeline with the sink stalled: exactly four beats fit.
    rdy_mode = 2;
    idle();
    idle();
    accepted = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (accepted < 6) begin
        in_valid = 1'b1;
        a = vecs[accepted].a; b = vecs[accepted].b;
        cin = vecs[accepted].cin; sub = vecs[accepted].sub;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(vecs[accepted].exp);
        accepted++;
      end
    end
    chk("stall_accepted", 64'(accepted), 64'd4);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    rdy_mode = 0;
    for (int i = accepted; i < 6; i++) send(vecs[i]);
    idle();
    wait_drain(50);

    // Random operands, random source gaps and random sink back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 1) == 1) idle();
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? ~v.a : W'($urandom);
      v.cin = 1'($urandom_range(0, 1));
      v.sub = 1'($urandom_range(0, 1));
      v.exp = model(v.a, v.b, v.cin, v.sub);
      send(v);
    end
    idle();
    rdy_mode = 0;
    wait_drain(500);

    // Reset with three beats in flight: they must vanish.
    rdy_mode = 2;
    idle();
    idle();
    send(vecs[5]);
    send(vecs[1]);
    send(vecs[3]);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_flags", 64'({cout, ovf, zero}), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rdy_mode = 0;
    repeat (12) idle();
    send(vecs[2]);
    idle();
    wait_drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
